// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : APB4 initiator turning register-space write/read request and
//            ack channels into APB transfers, one transfer outstanding,
//            round-robin between channels. Optional macro: APB_MST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     wreq_addr,
    input  logic [DATA_W-1:0]     wreq_data,
    input  logic [DATA_W/8-1:0]   wreq_strb,
    input  logic                  wreq_vld,
    output logic                  wreq_rdy,
    output logic                  wack_err,
    output logic                  wack_vld,
    input  logic                  wack_rdy,
    input  logic [ADDR_W-1:0]     rreq_addr,
    input  logic                  rreq_vld,
    output logic                  rreq_rdy,
    output logic [DATA_W-1:0]     rack_data,
    output logic                  rack_err,
    output logic                  rack_vld,
    input  logic                  rack_rdy,
    output logic [ADDR_W-1:0]     p_addr,
    output logic [2:0]            p_prot,
    output logic                  p_sel,
    output logic                  p_enable,
    output logic                  p_write,
    output logic [DATA_W-1:0]     p_wdata,
    output logic [DATA_W/8-1:0]   p_strb,
    input  logic                  p_ready,
    input  logic [DATA_W-1:0]     p_rdata,
    input  logic                  p_slverr
);

    localparam logic [ADDR_W-1:0] c_addr_mask = ~(ADDR_W'(3));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_wr;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_strb;
    logic                  r_write;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_capture;
    logic                  w_tmo_hit;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // Counts ACCESS cycles spent waiting; the last allowed cycle triggers the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ACCESS && !p_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == ST_ACCESS) && !p_ready &&
                       (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;

    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the channel that did not win last time is served.
                if (wreq_vld && (!rreq_vld || !r_last_wr)) begin
                    w_grant_wr = 1'b1;
                end else if (rreq_vld) begin
                    w_grant_rd = 1'b1;
                end
                if (w_grant_wr || w_grant_rd) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (p_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if ((r_write && wack_rdy) || (!r_write && rack_rdy)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_wr <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_write   <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant_wr) begin
                r_addr    <= wreq_addr & c_addr_mask;
                r_wdata   <= wreq_data;
                r_strb    <= wreq_strb;
                r_write   <= 1'b1;
                r_last_wr <= 1'b1;
            end else if (w_grant_rd) begin
                r_addr    <= rreq_addr & c_addr_mask;
                r_wdata   <= '0;
                r_strb    <= '0;
                r_write   <= 1'b0;
                r_last_wr <= 1'b0;
            end
            // Read data is only kept for clean reads so responses never leak stale data.
            if (w_capture) begin
                r_err   <= p_slverr;
                r_rdata <= (!r_write && !p_slverr) ? p_rdata : '0;
            end else if (w_tmo_hit) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    assign wreq_rdy  = w_grant_wr;
    assign rreq_rdy  = w_grant_rd;
    assign p_sel     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign p_enable  = (r_state == ST_ACCESS);
    assign p_addr    = r_addr;
    assign p_prot    = PROT;
    assign p_write   = r_write;
    assign p_wdata   = r_wdata;
    assign p_strb    = r_strb;
    assign wack_vld  = (r_state == ST_RESP) && r_write;
    assign rack_vld  = (r_state == ST_RESP) && !r_write;
    assign wack_err  = wack_vld && r_err;
    assign rack_err  = rack_vld && r_err;
    assign rack_data = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Self-checking bench for apb_master_bridge: directed scenarios plus
//            randomized transfers against a memory-backed reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int         c_tmo  = 8;
    localparam logic [2:0] c_prot = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wreq_addr = '0;
    logic [31:0] wreq_data = '0;
    logic [3:0]  wreq_strb = '0;
    logic        wreq_vld = 1'b0;
    logic        wreq_rdy;
    logic        wack_err;
    logic        wack_vld;
    logic        wack_rdy = 1'b0;
    logic [15:0] rreq_addr = '0;
    logic        rreq_vld = 1'b0;
    logic        rreq_rdy;
    logic [31:0] rack_data;
    logic        rack_err;
    logic        rack_vld;
    logic        rack_rdy = 1'b0;
    logic [15:0] p_addr;
    logic [2:0]  p_prot;
    logic        p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        p_slverr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // slave control (written by the stimulus thread only)
    int slv_waits = 0;
    bit slv_err = 1'b0;
    bit slv_hang = 1'b0;

    // slave observations (written by the slave thread only)
    int          sel_total = 0;
    int          obs_cnt = 0;
    logic        obs_write;
    logic [15:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_strb;

    logic [31:0] ref_mem [16];

    apb_master_bridge #(
        .ADDR_W         (16),
        .DATA_W         (32),
        .PROT           (c_prot),
        .TIMEOUT_CYCLES (c_tmo)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wreq_addr (wreq_addr),
        .wreq_data (wreq_data),
        .wreq_strb (wreq_strb),
        .wreq_vld  (wreq_vld),
        .wreq_rdy  (wreq_rdy),
        .wack_err  (wack_err),
        .wack_vld  (wack_vld),
        .wack_rdy  (wack_rdy),
        .rreq_addr (rreq_addr),
        .rreq_vld  (rreq_vld),
        .rreq_rdy  (rreq_rdy),
        .rack_data (rack_data),
        .rack_err  (rack_err),
        .rack_vld  (rack_vld),
        .rack_rdy  (rack_rdy),
        .p_addr    (p_addr),
        .p_prot    (p_prot),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_wdata   (p_wdata),
        .p_strb    (p_strb),
        .p_ready   (p_ready),
        .p_rdata   (p_rdata),
        .p_slverr  (p_slverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'hCAFE_F00D : 32'h1000_0000 + 32'h0101_0101 * i;
    endfunction

    // Behavioural APB slave with its own memory, programmable wait states and
    // error; it drives junk on p_rdata/p_slverr while not ready.
    initial begin
        logic [31:0] slv_mem [16];
        int acc_cnt;
        int i;
        for (int k = 0; k < 16; k++) slv_mem[k] = init_word(k);
        acc_cnt  = 0;
        p_ready  = 1'b0;
        p_rdata  = '0;
        p_slverr = 1'b0;
        forever begin
            @(negedge clk);
            if (p_sel) sel_total++;
            if (p_sel && p_enable) begin
                if (!slv_hang && acc_cnt == slv_waits) begin
                    i = int'(p_addr[5:2]);
                    p_ready  = 1'b1;
                    p_slverr = slv_err;
                    if (p_write) begin
                        p_rdata = $urandom;
                        if (!slv_err)
                            for (int b = 0; b < 4; b++)
                                if (p_strb[b]) slv_mem[i][8*b +: 8] = p_wdata[8*b +: 8];
                    end else begin
                        p_rdata = slv_err ? $urandom : slv_mem[i];
                    end
                    obs_write = p_write;
                    obs_addr  = p_addr;
                    obs_wdata = p_wdata;
                    obs_strb  = p_strb;
                    obs_cnt++;
                end else begin
                    p_ready  = 1'b0;
                    p_rdata  = $urandom;
                    p_slverr = 1'($urandom);
                end
                acc_cnt++;
            end else begin
                acc_cnt  = 0;
                p_ready  = 1'b0;
                p_rdata  = '0;
                p_slverr = 1'b0;
            end
        end
    end

    // One complete transfer on a single channel with all expectations derived
    // from the reference memory and the documented latency of 3 + wait states.
    task automatic run_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int waits, input bit err,
                            input bit hang, input int hold, input string tag);
        int          hs, lat, idx, sel0, obs0;
        bit          seen;
        logic [31:0] exp_rd;
        idx       = int'(addr[5:2]);
        hs        = 0;
        lat       = 0;
        slv_waits = waits;
        slv_err   = err;
        slv_hang  = hang;
        @(posedge clk); #1;
        sel0 = sel_total;
        obs0 = obs_cnt;
        if (wr) begin
            wreq_addr = addr; wreq_data = data; wreq_strb = strb; wreq_vld = 1'b1;
        end else begin
            rreq_addr = addr; rreq_vld = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr ? wreq_rdy : rreq_rdy) begin
                seen = 1'b1;
                hs   = cyc;
                chk({tag, "_other_rdy"}, wr ? rreq_rdy : wreq_rdy, 0);
            end
        end
        chk({tag, "_handshake"}, seen, 1);
        @(posedge clk); #1;
        wreq_vld = 1'b0;
        rreq_vld = 1'b0;
        exp_rd = '0;
        if (wr) begin
            if (!err && !hang)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_rd = (err || hang) ? 32'h0 : ref_mem[idx];
        end
        seen = 1'b0;
        for (int i = 0; i < waits + 20 && !seen; i++) begin
            @(negedge clk);
            if (wr ? wack_vld : rack_vld) begin
                seen = 1'b1;
                lat  = cyc - hs;
            end
        end
        chk({tag, "_resp_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_latency"}, lat, 3 + waits);
            chk({tag, "_sel_cycles"}, sel_total - sel0, 2 + waits);
            if (!hang) begin
                chk({tag, "_apb_count"}, obs_cnt - obs0, 1);
                chk({tag, "_apb_write"}, obs_write, wr);
                chk({tag, "_apb_addr"}, obs_addr, {addr[15:2], 2'b00});
                chk({tag, "_apb_wdata"}, obs_wdata, wr ? data : 32'h0);
                chk({tag, "_apb_strb"}, obs_strb, wr ? strb : 4'h0);
            end
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                chk({tag, "_vld"}, wr ? wack_vld : rack_vld, 1);
                chk({tag, "_other_vld"}, wr ? rack_vld : wack_vld, 0);
                chk({tag, "_err"}, wr ? wack_err : rack_err, err | hang);
                chk({tag, "_rdata"}, rack_data, exp_rd);
                chk({tag, "_sel_resp"}, p_sel, 0);
                chk({tag, "_rdy_resp"}, {wreq_rdy, rreq_rdy}, 0);
            end
            @(posedge clk); #1;
            if (wr) wack_rdy = 1'b1; else rack_rdy = 1'b1;
            @(posedge clk); #1;
            wack_rdy = 1'b0;
            rack_rdy = 1'b0;
            @(negedge clk);
            chk({tag, "_vld_clear"}, {wack_vld, rack_vld}, 0);
        end
    endtask

    initial begin
        int   wn, rn, viol;
        logic got [$];
        logic exp_order [4];
        bit   seen;
        bit   hw, hr;

        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p_sel", p_sel, 0);
        chk("rst_p_enable", p_enable, 0);
        chk("rst_p_write", p_write, 0);
        chk("rst_p_addr", p_addr, 0);
        chk("rst_p_wdata_strb", {p_wdata, p_strb}, 0);
        chk("rst_p_prot", p_prot, c_prot);
        chk("rst_acks", {wack_vld, wack_err, rack_vld, rack_err}, 0);
        chk("rst_rack_data", rack_data, 0);
        chk("rst_req_rdy", {wreq_rdy, rreq_rdy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_xfer(1'b1, 16'h0004, 32'hA5A5_1234, 4'b0011, 0, 1'b0, 1'b0, 0, "t1_write");
        run_xfer(1'b0, 16'h0008, 32'h0, 4'h0, 3, 1'b0, 1'b0, 1, "t2_read");
        run_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 0, 1'b0, 1'b0, 0, "t1_readback");

        // both channels valid from reset: expected alternation W, R, W, R
        @(posedge clk); #1;
        rst_n = 1'b0;
        wreq_addr = 16'h0030; wreq_data = 32'h5A5A_0F0F; wreq_strb = 4'hF;
        rreq_addr = 16'h0034;
        wreq_vld = 1'b1; rreq_vld = 1'b1;
        wack_rdy = 1'b1; rack_rdy = 1'b1;
        slv_waits = 0; slv_err = 1'b0; slv_hang = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wn = 2; rn = 2; viol = 0;
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
        for (int c = 0; c < 60 && (wn > 0 || rn > 0); c++) begin
            @(negedge clk);
            hw = wreq_rdy;
            hr = rreq_rdy;
            if (hw && hr) viol++;
            if ((hw || hr) && (p_sel || wack_vld || rack_vld)) viol++;
            if (hw) got.push_back(1'b1);
            else if (hr) got.push_back(1'b0);
            @(posedge clk); #1;
            if (hw) begin wn--; if (wn == 0) wreq_vld = 1'b0; end
            if (hr) begin rn--; if (rn == 0) rreq_vld = 1'b0; end
        end
        repeat (6) @(posedge clk);
        #1;
        wack_rdy = 1'b0; rack_rdy = 1'b0;
        wreq_vld = 1'b0; rreq_vld = 1'b0;
        ref_mem[12] = 32'h5A5A_0F0F;
        chk("t3_rdy_violations", viol, 0);
        chk("t3_count", got.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_order%0d", k), (k < got.size()) ? got[k] : 1'bx, exp_order[k]);

        // slave error on a read, response held for 5 cycles
        run_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 1, 1'b1, 1'b0, 5, "t4_err_read");

        // reset during ACCESS aborts silently
        slv_waits = 10; slv_err = 1'b0; slv_hang = 1'b0;
        @(posedge clk); #1;
        wreq_addr = 16'h0020; wreq_data = 32'h1111_2222; wreq_strb = 4'hF; wreq_vld = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wreq_rdy) seen = 1'b1;
        end
        @(posedge clk); #1;
        wreq_vld = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (p_enable) seen = 1'b1;
        end
        chk("t5_reached_access", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_sel_async", {p_sel, p_enable}, 0);
        repeat (2) @(negedge clk);
        chk("t5_sel_in_rst", {p_sel, p_enable}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wack_vld || rack_vld || p_sel) viol++;
        end
        chk("t5_no_resp", viol, 0);
        run_xfer(1'b1, 16'h0022, 32'h3333_4444, 4'b1100, 0, 1'b0, 1'b0, 0, "t5_after_rst");
        run_xfer(1'b0, 16'h0020, 32'h0, 4'h0, 0, 1'b0, 1'b0, 0, "t5_readback");

`ifdef APB_MST_TIMEOUT_EN
        run_xfer(1'b0, 16'h0008, 32'h0, 4'h0, c_tmo - 1, 1'b0, 1'b1, 0, "t6_timeout");
        slv_hang = 1'b0;
`endif

        // randomized transfers against the reference memory
        for (int n = 0; n < 30; n++) begin
            run_xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
                     int'($urandom_range(0, 3)), ($urandom % 5) == 0, 1'b0,
                     int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
